// File: rtl/pe_tile_pkg.sv
// pe_tile_pkg
//   Shared types, constants and arithmetic helpers for the PE tile.
//   - dataflow_e   : per-column dataflow request (OS / WS)
//   - DF_SUP_*     : values for the tile's DATAFLOW parameter
//   - SHIFT_W      : width of the output right-shift amount
//   - mode_supported, sat_to, rshift : helpers used by pe_cell / pe_tile_array
// Configuration macro:
//   PE_TILE_SHIFT_ROUND_EN - when defined, rshift rounds half-up instead of
//                            truncating toward negative infinity.
package pe_tile_pkg;

  typedef enum logic {
    DF_OS = 1'b0,
    DF_WS = 1'b1
  } dataflow_e;

  localparam int DF_SUP_OS   = 0;
  localparam int DF_SUP_WS   = 1;
  localparam int DF_SUP_BOTH = 2;

  localparam int SHIFT_W = 5;

  // True when a column requesting dataflow df may update under selector sel.
  function automatic logic mode_supported(input int sel, input dataflow_e df);
    logic ok;
    case (sel)
      DF_SUP_OS: ok = (df == DF_OS);
      DF_SUP_WS: ok = (df == DF_WS);
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Signed saturation of a wide value into a w-bit signed range.
  // Callers truncate the 64-bit result to w bits afterwards.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] x,
                                                input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      r = hi;
    else if (x < lo) r = lo;
    else             r = x;
    return r;
  endfunction

  // Arithmetic right shift of an accumulator value. The rounding variant adds
  // half an LSB of the result first; shift=0 is always a plain copy.
  function automatic logic signed [63:0] rshift(input logic signed [63:0] x,
                                                input logic [SHIFT_W-1:0] sh);
    logic signed [63:0] t;
    t = x;
`ifdef PE_TILE_SHIFT_ROUND_EN
    if (sh != '0) t = t + (64'sd1 <<< (sh - 5'd1));
`endif
    return t >>> sh;
  endfunction

endpackage

// File: rtl/pe_tile_array_cell.sv
// pe_cell
//   One multiply-accumulate PE with double-buffered accumulators c1/c2.
//   'propagate' picks which register is current (cur) and which accumulates
//   or holds weights (oth). out_b/out_c are combinational.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   en            : column valid and requested mode supported
//   a             : signed IN_W operand from this PE's row
//   in_b, in_d    : signed OUT_W operands from the PE above (or tile edge)
//   dataflow      : DF_OS / DF_WS
//   propagate     : accumulator select
//   shift         : OS output right-shift amount
//   out_b, out_c  : signed OUT_W results toward the PE below
//   last_prop     : propagate seen on the last enabled cycle
module pe_cell
  import pe_tile_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 20,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [OUT_W-1:0] in_b,
  input  logic signed [OUT_W-1:0] in_d,
  input  dataflow_e               dataflow,
  input  logic                    propagate,
  input  logic [SHIFT_W-1:0]      shift,
  output logic signed [OUT_W-1:0] out_b,
  output logic signed [OUT_W-1:0] out_c,
  output logic                    last_prop
);

  localparam int PROD_W = IN_W + OUT_W;
  localparam int WS_W   = IN_W + ACC_W + 1;

  logic signed [ACC_W-1:0]  c1;
  logic signed [ACC_W-1:0]  c2;
  logic signed [ACC_W-1:0]  cur;
  logic signed [ACC_W-1:0]  oth;
  logic signed [ACC_W-1:0]  d_ext;
  logic signed [ACC_W-1:0]  oth_next;
  logic signed [PROD_W-1:0] prod_ab;
  logic signed [WS_W-1:0]   ws_sum;

  assign cur      = propagate ? c1 : c2;
  assign oth      = propagate ? c2 : c1;
  assign d_ext    = ACC_W'(in_d);
  // Full-width a*b, then sign-extended; the add wraps modulo 2^ACC_W.
  assign prod_ab  = PROD_W'(a) * PROD_W'(in_b);
  assign oth_next = oth + ACC_W'(prod_ab);
  // WS partial sum kept wide enough that saturation sees the true value.
  assign ws_sum   = WS_W'(in_b) + WS_W'(a) * WS_W'(oth);

  // Output path: pass b/d straight through unless this PE is enabled, then
  // emit the current accumulator (OS: shifted) and, in WS, the updated sum.
  always_comb begin
    out_b = in_b;
    out_c = in_d;
    if (en) begin
      if (dataflow == DF_OS) begin
        out_c = OUT_W'(sat_to(rshift(64'(cur), shift), OUT_W));
      end else begin
        out_c = OUT_W'(sat_to(64'(cur), OUT_W));
        out_b = OUT_W'(sat_to(64'(ws_sum), OUT_W));
      end
    end
  end

  // State update: cur always reloads from in_d; in OS the other register
  // accumulates, in WS it holds the stationary weight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1        <= '0;
      c2        <= '0;
      last_prop <= 1'b0;
    end else if (en) begin
      last_prop <= propagate;
      if (propagate) begin
        c1 <= d_ext;
        if (dataflow == DF_OS) c2 <= oth_next;
      end else begin
        c2 <= d_ext;
        if (dataflow == DF_OS) c1 <= oth_next;
      end
    end
  end

endmodule

// File: rtl/pe_tile_array.sv
// pe_tile_array
//   ROWS x COLS grid of pe_cell MAC units followed by a registered edge stage.
//   a travels along a row; b and d chain down each column (out_b -> in_b,
//   out_c -> in_d). Everything leaving the tile is registered, so every
//   output is its input (or grid result) one cycle later.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   in_a / out_a                  : ROWS lanes of IN_W
//   in_b, in_d / out_b, out_c     : COLS lanes of OUT_W
//   in_dataflow, in_propagate, in_shift, in_id, in_last, in_valid
//                                 : per-column control, passed to out_*
//   bad_dataflow                  : a valid column asked for an excluded mode
// Configuration macro:
//   PE_TILE_SHIFT_ROUND_EN (see pe_tile_pkg) - round-half-up OS output shift.
module pe_tile_array
  import pe_tile_pkg::*;
#(
  parameter int ROWS     = 2,
  parameter int COLS     = 2,
  parameter int IN_W     = 8,
  parameter int OUT_W    = 20,
  parameter int ACC_W    = 32,
  parameter int ID_W     = 3,
  parameter int DATAFLOW = DF_SUP_BOTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ROWS*IN_W-1:0]     in_a,
  input  logic [COLS*OUT_W-1:0]    in_b,
  input  logic [COLS*OUT_W-1:0]    in_d,
  input  logic [COLS-1:0]          in_dataflow,
  input  logic [COLS-1:0]          in_propagate,
  input  logic [COLS*SHIFT_W-1:0]  in_shift,
  input  logic [COLS*ID_W-1:0]     in_id,
  input  logic [COLS-1:0]          in_last,
  input  logic [COLS-1:0]          in_valid,
  output logic [ROWS*IN_W-1:0]     out_a,
  output logic [COLS*OUT_W-1:0]    out_b,
  output logic [COLS*OUT_W-1:0]    out_c,
  output logic [COLS-1:0]          out_dataflow,
  output logic [COLS-1:0]          out_propagate,
  output logic [COLS*SHIFT_W-1:0]  out_shift,
  output logic [COLS*ID_W-1:0]     out_id,
  output logic [COLS-1:0]          out_last,
  output logic [COLS-1:0]          out_valid,
  output logic                     bad_dataflow
);

  logic [OUT_W-1:0]     b_chain [ROWS+1][COLS];
  logic [OUT_W-1:0]     d_chain [ROWS+1][COLS];
  logic [COLS-1:0]      col_en;
  logic [COLS-1:0]      col_bad;
  logic [COLS*OUT_W-1:0] bottom_b;
  logic [COLS*OUT_W-1:0] bottom_c;
  // Kept per PE for the mesh's propagate-flip detection; not consumed here.
  logic [ROWS*COLS-1:0] last_prop_unused;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    // A column updates only when valid and its requested mode is built in.
    assign col_en[c]  = in_valid[c] &  mode_supported(DATAFLOW, dataflow_e'(in_dataflow[c]));
    assign col_bad[c] = in_valid[c] & ~mode_supported(DATAFLOW, dataflow_e'(in_dataflow[c]));
    assign b_chain[0][c] = in_b[c*OUT_W +: OUT_W];
    assign d_chain[0][c] = in_d[c*OUT_W +: OUT_W];
    assign bottom_b[c*OUT_W +: OUT_W] = b_chain[ROWS][c];
    assign bottom_c[c*OUT_W +: OUT_W] = d_chain[ROWS][c];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
      pe_cell #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .ACC_W(ACC_W)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .en       (col_en[c]),
        .a        (in_a[r*IN_W +: IN_W]),
        .in_b     (b_chain[r][c]),
        .in_d     (d_chain[r][c]),
        .dataflow (dataflow_e'(in_dataflow[c])),
        .propagate(in_propagate[c]),
        .shift    (in_shift[c*SHIFT_W +: SHIFT_W]),
        .out_b    (b_chain[r+1][c]),
        .out_c    (d_chain[r+1][c]),
        .last_prop(last_prop_unused[r*COLS+c])
      );
    end
  end

  // Edge register stage: captures every cycle regardless of valid, so
  // out_valid is simply in_valid one cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a         <= '0;
      out_b         <= '0;
      out_c         <= '0;
      out_dataflow  <= '0;
      out_propagate <= '0;
      out_shift     <= '0;
      out_id        <= '0;
      out_last      <= '0;
      out_valid     <= '0;
      bad_dataflow  <= 1'b0;
    end else begin
      out_a         <= in_a;
      out_b         <= bottom_b;
      out_c         <= bottom_c;
      out_dataflow  <= in_dataflow;
      out_propagate <= in_propagate;
      out_shift     <= in_shift;
      out_id        <= in_id;
      out_last      <= in_last;
      out_valid     <= in_valid;
      bad_dataflow  <= |col_bad;
    end
  end

endmodule

// File: tb/tb_pe_tile_array.sv
// tb_pe_tile_array
//   Directed bench for pe_tile_array. Three tiles share clock and reset:
//   a 1x1 tile supporting both modes, a 1x1 OS-only tile driven by the same
//   inputs, and a 2x2 tile for row/column chaining. Expected values are
//   hand-computed in the comments beside each step.
module tb_pe_tile_array;
  import pe_tile_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  // Shared 1x1 stimulus
  logic [7:0]  t_a;
  logic [19:0] t_b, t_d;
  logic        t_df, t_prop, t_last, t_valid;
  logic [4:0]  t_shift;
  logic [2:0]  t_id;

  // 1x1, both modes
  logic [7:0]  o1_a;
  logic [19:0] o1_b, o1_c;
  logic        o1_df, o1_prop, o1_last, o1_valid, o1_bad;
  logic [4:0]  o1_shift;
  logic [2:0]  o1_id;

  // 1x1, OS only
  logic [7:0]  oo_a;
  logic [19:0] oo_b, oo_c;
  logic        oo_df, oo_prop, oo_last, oo_valid, oo_bad;
  logic [4:0]  oo_shift;
  logic [2:0]  oo_id;

  // 2x2 stimulus and outputs
  logic [15:0] u_a, o2_a;
  logic [39:0] u_b, u_d, o2_b, o2_c;
  logic [1:0]  u_df, u_prop, u_last, u_valid;
  logic [1:0]  o2_df, o2_prop, o2_last, o2_valid;
  logic [9:0]  u_shift, o2_shift;
  logic [5:0]  u_id, o2_id;
  logic        o2_bad;

  pe_tile_array #(.ROWS(1), .COLS(1), .DATAFLOW(DF_SUP_BOTH)) dut_1x1 (
    .clk(clk), .rst(rst),
    .in_a(t_a), .in_b(t_b), .in_d(t_d), .in_dataflow(t_df),
    .in_propagate(t_prop), .in_shift(t_shift), .in_id(t_id),
    .in_last(t_last), .in_valid(t_valid),
    .out_a(o1_a), .out_b(o1_b), .out_c(o1_c), .out_dataflow(o1_df),
    .out_propagate(o1_prop), .out_shift(o1_shift), .out_id(o1_id),
    .out_last(o1_last), .out_valid(o1_valid), .bad_dataflow(o1_bad)
  );

  pe_tile_array #(.ROWS(1), .COLS(1), .DATAFLOW(DF_SUP_OS)) dut_os (
    .clk(clk), .rst(rst),
    .in_a(t_a), .in_b(t_b), .in_d(t_d), .in_dataflow(t_df),
    .in_propagate(t_prop), .in_shift(t_shift), .in_id(t_id),
    .in_last(t_last), .in_valid(t_valid),
    .out_a(oo_a), .out_b(oo_b), .out_c(oo_c), .out_dataflow(oo_df),
    .out_propagate(oo_prop), .out_shift(oo_shift), .out_id(oo_id),
    .out_last(oo_last), .out_valid(oo_valid), .bad_dataflow(oo_bad)
  );

  pe_tile_array #(.ROWS(2), .COLS(2), .DATAFLOW(DF_SUP_BOTH)) dut_2x2 (
    .clk(clk), .rst(rst),
    .in_a(u_a), .in_b(u_b), .in_d(u_d), .in_dataflow(u_df),
    .in_propagate(u_prop), .in_shift(u_shift), .in_id(u_id),
    .in_last(u_last), .in_valid(u_valid),
    .out_a(o2_a), .out_b(o2_b), .out_c(o2_c), .out_dataflow(o2_df),
    .out_propagate(o2_prop), .out_shift(o2_shift), .out_id(o2_id),
    .out_last(o2_last), .out_valid(o2_valid), .bad_dataflow(o2_bad)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and land 1 ns after the edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one 1x1 vector and clock it through the edge register.
  task automatic applyStimulus(input logic signed [7:0] a,
                               input logic signed [19:0] b,
                               input logic signed [19:0] d,
                               input logic df, input logic prop,
                               input logic [4:0] shift, input logic valid);
    t_a = a; t_b = b; t_d = d; t_df = df; t_prop = prop;
    t_shift = shift; t_valid = valid;
    tick();
  endtask

  task automatic checkOutput(input string tag,
                             input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    t_a = '0; t_b = '0; t_d = '0; t_df = 1'b0; t_prop = 1'b0;
    t_shift = '0; t_id = '0; t_last = 1'b0; t_valid = 1'b0;
    u_a = '0; u_b = '0; u_d = '0; u_df = '0; u_prop = '0;
    u_shift = '0; u_id = '0; u_last = '0; u_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // WS preload before a mid-run reset: c1 <= 6, out_b = 7 + 5*c2(0)
    t_id = 3'd3; t_last = 1'b1;
    applyStimulus(8'sd5, 20'sd7, 20'sd6, DF_WS, 1'b1, 5'd0, 1'b1);
    checkOutput("pre_valid", o1_valid, 1);
    checkOutput("pre_b", $signed(o1_b), 7);
    checkOutput("pre_a", $signed(o1_a), 5);
    checkOutput("pre_id", o1_id, 3);
    checkOutput("pre_last", o1_last, 1);

    // Asynchronous reset between edges clears outputs at once
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_valid", o1_valid, 0);
    checkOutput("rst_b", $signed(o1_b), 0);
    checkOutput("rst_c", $signed(o1_c), 0);
    checkOutput("rst_a", $signed(o1_a), 0);
    checkOutput("rst_id", o1_id, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    t_id = '0; t_last = 1'b0;

    // Preload was wiped: out_b = 10 + 3*c1(0)
    applyStimulus(8'sd3, 20'sd10, 20'sd0, DF_WS, 1'b0, 5'd0, 1'b1);
    checkOutput("post_rst_b", $signed(o1_b), 10);
    checkOutput("post_rst_c", $signed(o1_c), 0);

    // WS: preload c1 = 6, then out_b = 10 + 3*6 = 28
    applyStimulus(8'sd0, 20'sd0, 20'sd6, DF_WS, 1'b1, 5'd0, 1'b1);
    checkOutput("ws_load_c", $signed(o1_c), 0);
    applyStimulus(8'sd3, 20'sd10, 20'sd0, DF_WS, 1'b0, 5'd0, 1'b1);
    checkOutput("ws_b", $signed(o1_b), 28);
    checkOutput("ws_c", $signed(o1_c), 0);

    // OS: c1=7,c2=12 -> out 12 -> c1=17 read back
    do_reset();
    applyStimulus(8'sd3, 20'sd4, 20'sd7, DF_OS, 1'b1, 5'd0, 1'b1);
    checkOutput("os0_c", $signed(o1_c), 0);
    checkOutput("os0_b", $signed(o1_b), 4);
    applyStimulus(8'sd2, 20'sd5, 20'sd0, DF_OS, 1'b0, 5'd0, 1'b1);
    checkOutput("os1_c", $signed(o1_c), 12);
    applyStimulus(8'sd0, 20'sd0, 20'sd0, DF_OS, 1'b1, 5'd0, 1'b1);
    checkOutput("os2_c", $signed(o1_c), 17);

    // Shift: 14 >> 2 and -5 >> 1
    applyStimulus(8'sd2, 20'sd7, 20'sd0, DF_OS, 1'b1, 5'd0, 1'b1);
    applyStimulus(8'sd0, 20'sd0, 20'sd0, DF_OS, 1'b0, 5'd2, 1'b1);
`ifdef PE_TILE_SHIFT_ROUND_EN
    checkOutput("shift_pos", $signed(o1_c), 4);
`else
    checkOutput("shift_pos", $signed(o1_c), 3);
`endif
    applyStimulus(-8'sd1, 20'sd5, 20'sd0, DF_OS, 1'b1, 5'd0, 1'b1);
    applyStimulus(8'sd0, 20'sd0, 20'sd0, DF_OS, 1'b0, 5'd1, 1'b1);
`ifdef PE_TILE_SHIFT_ROUND_EN
    checkOutput("shift_neg", $signed(o1_c), -2);
`else
    checkOutput("shift_neg", $signed(o1_c), -3);
`endif

    // Saturation: +/-600000 clamps to the 20-bit range
    applyStimulus(8'sd100, 20'sd6000, 20'sd0, DF_OS, 1'b1, 5'd0, 1'b1);
    applyStimulus(8'sd0, 20'sd0, 20'sd0, DF_OS, 1'b0, 5'd0, 1'b1);
    checkOutput("sat_pos", $signed(o1_c), 524287);
    applyStimulus(-8'sd100, 20'sd6000, 20'sd0, DF_OS, 1'b1, 5'd0, 1'b1);
    applyStimulus(8'sd0, 20'sd0, 20'sd0, DF_OS, 1'b0, 5'd0, 1'b1);
    checkOutput("sat_neg", $signed(o1_c), -524288);

    // Invalid cycle: passthrough, no state change (c1 and c2 stay 0)
    applyStimulus(8'sd50, 20'sd50, 20'sd99, DF_OS, 1'b1, 5'd0, 1'b0);
    checkOutput("inv_valid", o1_valid, 0);
    checkOutput("inv_c", $signed(o1_c), 99);
    checkOutput("inv_b", $signed(o1_b), 50);
    applyStimulus(8'sd0, 20'sd0, 20'sd0, DF_OS, 1'b1, 5'd0, 1'b1);
    checkOutput("inv_c1", $signed(o1_c), 0);
    applyStimulus(8'sd0, 20'sd0, 20'sd0, DF_OS, 1'b0, 5'd0, 1'b1);
    checkOutput("inv_c2", $signed(o1_c), 0);

    // Mode check: WS request on the OS-only tile is flagged and ignored
    do_reset();
    applyStimulus(8'sd0, 20'sd0, 20'sd9, DF_WS, 1'b1, 5'd0, 1'b1);
    checkOutput("bad_os_tile", oo_bad, 1);
    checkOutput("bad_both_tile", o1_bad, 0);
    applyStimulus(8'sd0, 20'sd0, 20'sd0, DF_OS, 1'b1, 5'd0, 1'b1);
    checkOutput("bad_clear", oo_bad, 0);
    checkOutput("bad_hold_c1", $signed(oo_c), 0);
    checkOutput("good_c1", $signed(o1_c), 9);
    t_valid = 1'b0;

    // 2x2 OS: c2 accumulates 3*b in row 0 and 5*b in row 1
    do_reset();
    u_a = {8'd5, 8'd3}; u_b = {20'd4, 20'd2}; u_d = '0;
    u_df = 2'b00; u_prop = 2'b11; u_valid = 2'b11;
    tick();
    checkOutput("t2_out_a", o2_a, 16'h0503);
    checkOutput("t2_b0", $signed(o2_b[19:0]), 2);
    checkOutput("t2_b1", $signed(o2_b[39:20]), 4);
    checkOutput("t2_c0_init", $signed(o2_c[19:0]), 0);
    // Flip: bottom row emits its own sum, top row's sum shifts down
    u_a = '0; u_b = '0; u_prop = 2'b00;
    tick();
    checkOutput("t2_out_a_next", o2_a, 0);
    checkOutput("t2_c0_row1", $signed(o2_c[19:0]), 10);
    checkOutput("t2_c1_row1", $signed(o2_c[39:20]), 20);
    tick();
    checkOutput("t2_c0_row0", $signed(o2_c[19:0]), 6);
    checkOutput("t2_c1_row0", $signed(o2_c[39:20]), 12);

    // 2x2 WS: load weights row1 then row0, partial sums chain down
    u_df = 2'b11; u_prop = 2'b11;
    u_d = {20'sd7, 20'sd5};
    tick();
    u_d = {-20'sd1, 20'sd4};
    tick();
    u_prop = 2'b00; u_d = '0;
    u_a = {8'd3, 8'd2}; u_b = {20'd1, 20'd1};
    tick();
    // col0: 1 + 2*4 + 3*5 = 24 ; col1: 1 + 2*(-1) + 3*7 = 20
    checkOutput("t2_ws_b0", $signed(o2_b[19:0]), 24);
    checkOutput("t2_ws_b1", $signed(o2_b[39:20]), 20);
    checkOutput("t2_ws_df", o2_df, 3);
    u_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
